pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Program-counter controller for the core. Owns the PC register and selects the next PC each cycle:
//   sequential +1, absolute branch/call through the branch-target LUT, PC-relative branch, return from
//   a small hardware return stack, stall hold, or halt. Sits between instruction decode and the
//   instruction ROM; drives the LUT index and consumes the LUT target combinationally.
// PARAMETERS
//   D        10  PC / LUT target width; all PC arithmetic is mod 2**D
//   LA       4   branch-target LUT index width (2**LA entries)
//   RS_DEPTH 4   return-stack depth (entries of D bits), power of two >= 2
// PORTS
//   clk         in   1       clock, all state updates on rising edge
//   rst_n       in   1       asynchronous active-low reset
//   start       in   1       begin program from PC 0 (honoured in IDLE or HALT only)
//   stall       in   1       hold PC and all state this cycle
//   halt_req    in   1       decoded halt instruction at current PC
//   br_en       in   1       branch taken (condition already resolved by decode)
//   br_rel      in   1       0: absolute target = lut_target; 1: relative, PC + lut_target
//   call        in   1       call: push PC+1, jump to lut_target (absolute)
//   ret         in   1       return: pop return stack into PC
//   br_idx      in   LA      LUT index from instruction field
//   lut_addr    out  LA      to LUT addr; = br_idx combinationally
//   lut_target  in   D       from LUT target, same cycle
//   pc          out  D       current PC (to instruction ROM)
//   running     out  1       1 in RUN state
//   done        out  1       1 in HALT state
//   rs_ovf      out  1       sticky: call issued with return stack full
//   rs_unf      out  1       sticky: ret issued with return stack empty
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc=0, running=0, done=0, rs_ovf=0, rs_unf=0, stack count=0.
//   States: IDLE -> RUN on start. RUN -> HALT on halt_req & !stall. HALT -> RUN on start.
//   start in IDLE/HALT: pc<=0, stack count<=0, rs_ovf<=0, rs_unf<=0, done<=0; first fetch next cycle.
//   start in RUN: ignored. Control inputs ignored in IDLE/HALT; pc holds.
//   RUN, one decision per cycle, priority (highest first):
//     stall    : pc, stack, flags hold (halt/call/ret/br ignored that cycle)
//     halt_req : pc holds, state<=HALT (done=1, running=0 from next cycle)
//     ret      : count>0 -> pc<=top, count--; count==0 -> pc<=pc+1, rs_unf<=1
//     call     : pc<=lut_target; count<RS_DEPTH -> push pc+1, count++;
//                full -> push dropped, stack unchanged, rs_ovf<=1, jump still taken
//     br_en    : br_rel=0 -> pc<=lut_target; br_rel=1 -> pc<=pc+lut_target (lut_target two's
//                complement D bits, sum truncated to D bits, e.g. D=10: 4 + 0x3FF -> 3)
//     else     : pc<=pc+1, wraps 2**D-1 -> 0
//   Pushed return address pc+1 also wraps mod 2**D.
//   Latency: decision uses inputs of the cycle in which pc is presented; new pc visible after next
//   rising edge. No bubble on taken branch.
//   lut_addr = br_idx in every state (pure pass-through, no register).
//   rs_ovf/rs_unf clear only on reset or accepted start.
//   Reset mid-program: immediate return to IDLE, stack contents discarded.
// TESTING
//   1 reset then start; 5 cycles idle inputs -> pc 0,1,2,3,4,5; running=1, done=0.
//   2 pc=4, br_en=1, br_rel=1, lut_target=10'h3FF -> next pc=3; pc=1023 no branch -> next pc=0.
//   3 call idx with target 43 at pc=7 -> pc=43; later ret -> pc=8; stack count back to 0.
//   4 five nested calls (RS_DEPTH=4) -> rs_ovf=1 on 5th, jump taken; 5 rets -> 4 correct returns,
//     5th sets rs_unf=1 and pc increments.
//   5 halt_req with stall=1 -> pc holds, still RUN; stall=0 -> HALT, done=1; start -> pc=0, flags clear.
//   6 rst_n pulsed low mid-RUN between edges -> pc=0, IDLE, running=0 immediately (asynchronous).

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter controller. Owns the PC register and picks
//                the next PC each cycle: sequential +1, absolute branch/call
//                through the branch-target LUT, PC-relative branch, return
//                from a small hardware return stack, stall hold, or halt.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1    clock, all state updates on rising edge
//    rst_n         in   1    asynchronous active-low reset
//    i_start       in   1    begin program from PC 0 (IDLE/HALT only)
//    i_stall       in   1    hold PC and all state this cycle
//    i_halt_req    in   1    decoded halt instruction at current PC
//    i_br_en       in   1    branch taken
//    i_br_rel      in   1    0: absolute (lut target), 1: PC + lut target
//    i_call        in   1    push PC+1, jump to lut target
//    i_ret         in   1    pop return stack into PC
//    i_br_idx      in   LA   LUT index from instruction field
//    o_lut_addr    out  LA   LUT address (= i_br_idx, combinational)
//    i_lut_target  in   D    LUT target, same cycle
//    o_pc          out  D    current PC
//    o_running     out  1    1 in RUN state
//    o_done        out  1    1 in HALT state
//    o_rs_ovf      out  1    sticky: call with return stack full
//    o_rs_unf      out  1    sticky: ret with return stack empty
// ============================================================================
module pc_sequencer #(
  parameter int D        = 10,
  parameter int LA       = 4,
  parameter int RS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_stall,
  input  logic          i_halt_req,
  input  logic          i_br_en,
  input  logic          i_br_rel,
  input  logic          i_call,
  input  logic          i_ret,
  input  logic [LA-1:0] i_br_idx,
  output logic [LA-1:0] o_lut_addr,
  input  logic [D-1:0]  i_lut_target,
  output logic [D-1:0]  o_pc,
  output logic          o_running,
  output logic          o_done,
  output logic          o_rs_ovf,
  output logic          o_rs_unf
);

  localparam int SP_W  = $clog2(RS_DEPTH);
  localparam int CNT_W = SP_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [D-1:0]     r_pc;
  logic [D-1:0]     w_pc_nxt;
  logic [D-1:0]     w_pc_inc;
  logic [CNT_W-1:0] r_count;
  logic [D-1:0]     r_stack [RS_DEPTH];
  logic             r_rs_ovf;
  logic             r_rs_unf;

  logic             w_start_acc;
  logic             w_run_act;
  logic             w_full;
  logic             w_empty;
  logic [SP_W-1:0]  w_top_idx;
  logic [SP_W-1:0]  w_push_idx;
  logic [CNT_W-1:0] w_count_dec;
  logic             w_push;
  logic             w_pop;
  logic             w_set_ovf;
  logic             w_set_unf;

  // start is only honoured outside RUN; in RUN it is ignored entirely.
  assign w_start_acc = i_start && (r_state != S_RUN);
  assign w_run_act   = (r_state == S_RUN) && !i_stall;
  assign w_pc_inc    = r_pc + D'(1);
  assign w_full      = (r_count == CNT_W'(RS_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_count_dec = r_count - CNT_W'(1);
  assign w_top_idx   = w_count_dec[SP_W-1:0];
  assign w_push_idx  = r_count[SP_W-1:0];

  assign o_lut_addr  = i_br_idx;
  assign o_pc        = r_pc;
  assign o_rs_ovf    = r_rs_ovf;
  assign o_rs_unf    = r_rs_unf;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_RUN;
      S_RUN:  if (i_halt_req && !i_stall) w_state_nxt = S_HALT;
      S_HALT: if (i_start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_running = 1'b0;
    o_done    = 1'b0;
    case (r_state)
      S_RUN:  o_running = 1'b1;
      S_HALT: o_done    = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-PC selection, one decision per RUN cycle in priority order:
  // stall > halt > ret > call > branch > sequential.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (w_run_act) begin
      if (i_halt_req) begin
        w_pc_nxt = r_pc;
      end else if (i_ret) begin
        if (!w_empty) begin
          w_pc_nxt = r_stack[w_top_idx];
          w_pop    = 1'b1;
        end else begin
          // Underflow: behave as a plain sequential step and flag it.
          w_pc_nxt  = w_pc_inc;
          w_set_unf = 1'b1;
        end
      end else if (i_call) begin
        // The jump is taken even when the push has to be dropped.
        w_pc_nxt = i_lut_target;
        if (!w_full) begin
          w_push = 1'b1;
        end else begin
          w_set_ovf = 1'b1;
        end
      end else if (i_br_en) begin
        // Relative offset is two's complement; D-bit truncation gives the wrap.
        w_pc_nxt = i_br_rel ? (r_pc + i_lut_target) : i_lut_target;
      end else begin
        w_pc_nxt = w_pc_inc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // PC, stack pointer and sticky flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_count  <= '0;
      r_rs_ovf <= 1'b0;
      r_rs_unf <= 1'b0;
    end else if (w_start_acc) begin
      r_pc     <= '0;
      r_count  <= '0;
      r_rs_ovf <= 1'b0;
      r_rs_unf <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_push) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_count <= w_count_dec;
      end
      if (w_set_ovf) r_rs_ovf <= 1'b1;
      if (w_set_unf) r_rs_unf <= 1'b1;
    end
  end

  // Stack storage needs no reset: entries above the count are never read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer, directed scenarios plus
//                randomized control traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int D  = 10;
  localparam int LA = 4;
  localparam int RS = 4;
  localparam int PCMOD = 1 << D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stall, halt_req, br_en, br_rel, call, ret;
  logic [LA-1:0] br_idx;
  logic [LA-1:0] lut_addr;
  logic [D-1:0]  lut_target;
  logic [D-1:0]  pc;
  logic          running, done, rs_ovf, rs_unf;

  logic [D-1:0]  lut_mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 idle, 1 run, 2 halt
  int m_st, m_pc, m_ovf, m_unf;
  int m_q[$];

  always #5 clk = ~clk;

  assign lut_target = lut_mem[lut_addr];

  pc_sequencer #(.D(D), .LA(LA), .RS_DEPTH(RS)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_stall(stall),
    .i_halt_req(halt_req), .i_br_en(br_en), .i_br_rel(br_rel),
    .i_call(call), .i_ret(ret), .i_br_idx(br_idx), .o_lut_addr(lut_addr),
    .i_lut_target(lut_target), .o_pc(pc), .o_running(running),
    .o_done(done), .o_rs_ovf(rs_ovf), .o_rs_unf(rs_unf)
  );

  task automatic idle_inputs();
    start = 0; stall = 0; halt_req = 0; br_en = 0; br_rel = 0;
    call = 0; ret = 0; br_idx = '0;
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_ovf = 0; m_unf = 0; m_q.delete();
  endtask

  task automatic model_step();
    int tgt;
    tgt = int'(lut_mem[br_idx]);
    if (m_st != 1) begin
      if (start) begin
        m_pc = 0; m_q.delete(); m_ovf = 0; m_unf = 0; m_st = 1;
      end
    end else if (!stall) begin
      if (halt_req) m_st = 2;
      else if (ret) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else begin m_pc = (m_pc + 1) % PCMOD; m_unf = 1; end
      end else if (call) begin
        if (m_q.size() < RS) m_q.push_back((m_pc + 1) % PCMOD);
        else m_ovf = 1;
        m_pc = tgt;
      end else if (br_en) m_pc = br_rel ? (m_pc + tgt) % PCMOD : tgt;
      else m_pc = (m_pc + 1) % PCMOD;
    end
  endtask

  // Apply current inputs across one rising edge; outputs sampled 1 unit later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_program();
    idle_inputs();
    rst_n = 0; #2; rst_n = 1;
    model_reset();
    @(posedge clk); #1;
    start = 1; tick(); start = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pc !== '0 || running !== 1'b0 || done !== 1'b0 || rs_ovf !== 1'b0 || rs_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%0d run=%b done=%b ovf=%b unf=%b, required all 0", pc, running, done, rs_ovf, rs_unf);
    end
    rst_n = 1;
    tick();
    n_checks++;
    if (pc !== '0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: pc=%0d run=%b, required pc=0 run=0", pc, running);
    end
  endtask

  task automatic test_sequential();
    begin_program();
    n_checks++;
    if (pc !== 10'd0 || running !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_state: pc=%0d run=%b done=%b, required 0 1 0", pc, running, done);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (pc !== D'(i) || running !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_pc[%0d]: pc=%0d run=%b, required pc=%0d run=1", i, pc, running, i);
      end
    end
  endtask

  task automatic test_branch_wrap();
    begin_program();
    repeat (4) tick();
    lut_mem[3] = 10'h3FF;
    br_idx = 4'd3; br_en = 1; br_rel = 1;
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== 10'd3) begin
      n_fail++;
      $display("FAIL rel_branch_neg: pc=%0d, required 3", pc);
    end
    lut_mem[5] = 10'd1023;
    br_idx = 4'd5; br_en = 1; br_rel = 0;
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== 10'd1023) begin
      n_fail++;
      $display("FAIL abs_branch: pc=%0d, required 1023", pc);
    end
    tick();
    n_checks++;
    if (pc !== 10'd0) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%0d, required 0", pc);
    end
  endtask

  task automatic test_call_ret();
    begin_program();
    repeat (7) tick();
    lut_mem[2] = 10'd43;
    br_idx = 4'd2; call = 1;
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== 10'd43) begin
      n_fail++;
      $display("FAIL call_target: pc=%0d, required 43", pc);
    end
    repeat (2) tick();
    ret = 1;
    tick();
    n_checks++;
    if (pc !== 10'd8 || rs_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_addr: pc=%0d unf=%b, required pc=8 unf=0", pc, rs_unf);
    end
    // A second return finds the stack empty again.
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== 10'd9 || rs_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL stack_empty_after_ret: pc=%0d unf=%b, required pc=9 unf=1", pc, rs_unf);
    end
  endtask

  task automatic test_nested_overflow();
    int exp_ret[5];
    begin_program();
    for (int k = 0; k < 5; k++) lut_mem[8+k] = D'(100 + 20*k);
    for (int k = 0; k < 5; k++) begin
      br_idx = LA'(8 + k); call = 1;
      tick();
      n_checks++;
      if (pc !== D'(100 + 20*k) || rs_ovf !== (k == 4)) begin
        n_fail++;
        $display("FAIL nested_call[%0d]: pc=%0d ovf=%b, required pc=%0d ovf=%0d", k, pc, rs_ovf, 100 + 20*k, (k == 4));
      end
    end
    idle_inputs();
    exp_ret[0] = 141; exp_ret[1] = 121; exp_ret[2] = 101; exp_ret[3] = 1; exp_ret[4] = 2;
    for (int k = 0; k < 5; k++) begin
      ret = 1;
      tick();
      n_checks++;
      if (pc !== D'(exp_ret[k]) || rs_unf !== (k == 4) || rs_ovf !== 1'b1) begin
        n_fail++;
        $display("FAIL nested_ret[%0d]: pc=%0d unf=%b ovf=%b, required pc=%0d unf=%0d ovf=1", k, pc, rs_unf, rs_ovf, exp_ret[k], (k == 4));
      end
    end
    idle_inputs();
  endtask

  task automatic test_halt_stall();
    begin_program();
    ret = 1; tick(); idle_inputs();          // pc=1, unf set
    repeat (2) tick();                        // pc=3
    halt_req = 1; stall = 1;
    tick();
    n_checks++;
    if (pc !== 10'd3 || running !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_over_halt: pc=%0d run=%b done=%b, required 3 1 0", pc, running, done);
    end
    stall = 0;
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== 10'd3 || running !== 1'b0 || done !== 1'b1 || rs_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_entry: pc=%0d run=%b done=%b unf=%b, required 3 0 1 1", pc, running, done, rs_unf);
    end
    br_en = 1; call = 1; ret = 1; br_idx = 4'd2;
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== 10'd3 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_ignores_ctrl: pc=%0d done=%b, required 3 1", pc, done);
    end
    start = 1;
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== 10'd0 || running !== 1'b1 || done !== 1'b0 || rs_unf !== 1'b0 || rs_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: pc=%0d run=%b done=%b unf=%b ovf=%b, required 0 1 0 0 0", pc, running, done, rs_unf, rs_ovf);
    end
  endtask

  task automatic test_async_reset();
    begin_program();
    repeat (3) tick();
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (pc !== 10'd0 || running !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%0d run=%b done=%b, required 0 0 0", pc, running, done);
    end
    #1;
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;
    br_en = 1; br_idx = 4'd2;
    tick();
    idle_inputs();
    n_checks++;
    if (pc !== 10'd0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: pc=%0d run=%b, required 0 0", pc, running);
    end
  endtask

  task automatic test_random();
    begin_program();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) lut_mem[$urandom_range(0, 15)] = D'($urandom);
      start    = ($urandom_range(0, 19) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      halt_req = ($urandom_range(0, 39) == 0);
      ret      = ($urandom_range(0, 5) == 0);
      call     = ($urandom_range(0, 5) == 0);
      br_en    = ($urandom_range(0, 3) == 0);
      br_rel   = $urandom_range(0, 1);
      br_idx   = LA'($urandom);
      #1;
      n_checks++;
      if (lut_addr !== br_idx) begin
        n_fail++;
        $display("FAIL rnd_lut_addr[%0d]: lut_addr=%0d, required %0d", c, lut_addr, br_idx);
      end
      tick();
      n_checks++;
      if (pc !== D'(m_pc) || running !== (m_st == 1) || done !== (m_st == 2) ||
          rs_ovf !== m_ovf[0] || rs_unf !== m_unf[0]) begin
        n_fail++;
        $display("FAIL rnd_cycle[%0d]: pc=%0d run=%b done=%b ovf=%b unf=%b, required pc=%0d run=%0d done=%0d ovf=%0d unf=%0d",
                 c, pc, running, done, rs_ovf, rs_unf, m_pc, (m_st == 1), (m_st == 2), m_ovf, m_unf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut_mem[i] = D'($urandom);
    idle_inputs();
    rst_n = 0;
    model_reset();
    test_reset();
    test_sequential();
    test_branch_wrap();
    test_call_ret();
    test_nested_overflow();
    test_halt_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
